// File: rtl/costas_loop_filter.sv
// Costas loop phase detector and PI loop filter: sign-based I/Q error, integrate-and-dump,
// then a saturating proportional-integral filter driving the NCO phase step.
module costas_loop_filter #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned DELTA_PHASE_WIDTH = 10,
  parameter int unsigned ACC_WIDTH         = 24,
  parameter int unsigned KP_SHIFT          = 4,
  parameter int unsigned KI_SHIFT          = 8,
  parameter int unsigned DUMP_LEN          = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                valid_i,
  input  logic signed [DATA_WIDTH-1:0]        i_i,
  input  logic signed [DATA_WIDTH-1:0]        q_i,
  input  logic                                mode_i,
  input  logic                                freeze_i,
  input  logic                                clear_i,
  output logic signed [DELTA_PHASE_WIDTH-1:0] delta_phase_o,
  output logic                                valid_o,
  output logic                                sat_o
);

  localparam int unsigned EW    = DATA_WIDTH + 2;
  localparam int unsigned DumpW = EW + $clog2(DUMP_LEN);
  localparam int unsigned CntW  = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
  localparam int unsigned MaxA  = (DumpW > ACC_WIDTH) ? DumpW : ACC_WIDTH;
  localparam int unsigned MaxB  = (MaxA > DELTA_PHASE_WIDTH) ? MaxA : DELTA_PHASE_WIDTH;
  // Two guard bits so every sum below is exact before clamping.
  localparam int unsigned SumW  = MaxB + 2;

  localparam logic signed [SumW-1:0] AccMax =
      {{(SumW - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic signed [SumW-1:0] AccMin = ~AccMax;
  localparam logic signed [SumW-1:0] DpMax =
      {{(SumW - DELTA_PHASE_WIDTH + 1){1'b0}}, {(DELTA_PHASE_WIDTH - 1){1'b1}}};
  localparam logic signed [SumW-1:0] DpMin = ~DpMax;
  localparam logic [CntW-1:0] CntLast = CntW'(DUMP_LEN - 1);

  // Stage 1: phase error
  logic signed [EW-1:0] i_ext, q_ext, e_bpsk, e_qpsk, e_d, e_q;
  logic                 e_valid_d, e_valid_q;

  always_comb begin
    i_ext  = {{2{i_i[DATA_WIDTH-1]}}, i_i};
    q_ext  = {{2{q_i[DATA_WIDTH-1]}}, q_i};
    e_bpsk = i_i[DATA_WIDTH-1] ? -q_ext : q_ext;
    e_qpsk = e_bpsk - (q_i[DATA_WIDTH-1] ? -i_ext : i_ext);
    e_d       = e_q;
    e_valid_d = 1'b0;
    if (clear_i) begin
      e_d = '0;
    end else if (valid_i) begin
      e_d       = mode_i ? e_qpsk : e_bpsk;
      e_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q       <= '0;
      e_valid_q <= 1'b0;
    end else begin
      e_q       <= e_d;
      e_valid_q <= e_valid_d;
    end
  end

  // Stage 2: integrate and dump
  logic signed [DumpW-1:0] acc_d, acc_q, acc_sum, dump_d, dump_q;
  logic [CntW-1:0]         cnt_d, cnt_q;
  logic                    dump_valid_d, dump_valid_q;

  always_comb begin
    acc_sum      = acc_q + {{(DumpW - EW){e_q[EW-1]}}, e_q};
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    dump_d       = dump_q;
    dump_valid_d = 1'b0;
    if (clear_i) begin
      acc_d  = '0;
      cnt_d  = '0;
      dump_d = '0;
    end else if (e_valid_q) begin
      if (cnt_q == CntLast) begin
        dump_d       = acc_sum;
        dump_valid_d = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      dump_q       <= '0;
      dump_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dump_q       <= dump_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  // Stage 3: PI filter with saturation
  logic signed [SumW-1:0]              dump_ext, prop, ki_term, integ_ext, integ_sum, out_sum;
  logic signed [ACC_WIDTH-1:0]         integ_sat, integ_next, integ_d, integ_q;
  logic signed [DELTA_PHASE_WIDTH-1:0] delta_sat, delta_d, delta_q;
  logic                                clip, sat_d, sat_q, valid_d, valid_q;

  always_comb begin
    dump_ext  = {{(SumW - DumpW){dump_q[DumpW-1]}}, dump_q};
    prop      = dump_ext >>> KP_SHIFT;
    ki_term   = dump_ext >>> KI_SHIFT;
    integ_ext = {{(SumW - ACC_WIDTH){integ_q[ACC_WIDTH-1]}}, integ_q};
    integ_sum = integ_ext + ki_term;
    if (integ_sum > AccMax) begin
      integ_sat = AccMax[ACC_WIDTH-1:0];
    end else if (integ_sum < AccMin) begin
      integ_sat = AccMin[ACC_WIDTH-1:0];
    end else begin
      integ_sat = integ_sum[ACC_WIDTH-1:0];
    end
    integ_next = freeze_i ? integ_q : integ_sat;
    out_sum    = prop + {{(SumW - ACC_WIDTH){integ_next[ACC_WIDTH-1]}}, integ_next};
    clip       = 1'b1;
    if (out_sum > DpMax) begin
      delta_sat = DpMax[DELTA_PHASE_WIDTH-1:0];
    end else if (out_sum < DpMin) begin
      delta_sat = DpMin[DELTA_PHASE_WIDTH-1:0];
    end else begin
      delta_sat = out_sum[DELTA_PHASE_WIDTH-1:0];
      clip      = 1'b0;
    end

    integ_d = integ_q;
    delta_d = delta_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    if (clear_i) begin
      integ_d = '0;
      delta_d = '0;
      sat_d   = 1'b0;
    end else if (dump_valid_q) begin
      integ_d = integ_next;
      delta_d = delta_sat;
      sat_d   = clip;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q <= '0;
      delta_q <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      integ_q <= integ_d;
      delta_q <= delta_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
    end
  end

  assign delta_phase_o = delta_q;
  assign sat_o         = sat_q;
  assign valid_o       = valid_q;

endmodule

// File: doc/costas_loop_filter.md
COSTAS_LOOP_FILTER -- requirements
Module: costas_loop_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of signed I/Q input samples.
REQ-002 SHALL have parameter DELTA_PHASE_WIDTH, default 10: width of signed delta_phase_o, the NCO phase-step control.
REQ-003 SHALL have parameter ACC_WIDTH, default 24: width of the signed integrator and PI sum.
REQ-004 SHALL have parameters KP_SHIFT (default 4) and KI_SHIFT (default 8): arithmetic right-shift gains of the proportional and integral paths.
REQ-005 SHALL have parameter DUMP_LEN, default 4, range 1..256: error samples summed per loop update.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port valid_i, input, 1 bit: i_i/q_i qualifier.
REQ-009 SHALL have ports i_i and q_i, input, signed DATA_WIDTH: derotated baseband sample.
REQ-010 SHALL have port mode_i, input, 1 bit: 0 = BPSK detector, 1 = QPSK detector.
REQ-011 SHALL have port freeze_i, input, 1 bit: hold the integrator.
REQ-012 SHALL have port clear_i, input, 1 bit: synchronous clear of all loop state.
REQ-013 SHALL have port delta_phase_o, output, signed DELTA_PHASE_WIDTH: loop-filter output to the NCO.
REQ-014 SHALL have port valid_o, output, 1 bit: one-cycle pulse on each delta_phase_o update.
REQ-015 SHALL have port sat_o, output, 1 bit: last update was clipped.

Function
REQ-016 SHALL define sgn(x) = +1 for x >= 0, -1 for x < 0.
REQ-017 Stage 1 SHALL register e on valid_i: BPSK e = sgn(I)*Q; QPSK e = sgn(I)*Q - sgn(Q)*I; width DATA_WIDTH+2, exact (no overflow at -2^(DATA_WIDTH-1)); no multipliers.
REQ-018 Stage 2 SHALL add each valid e to a dump accumulator (width DATA_WIDTH+2+clog2(DUMP_LEN)) with sample counter 0..DUMP_LEN-1; on the DUMP_LEN-th e it SHALL register dump = acc + e, zero acc and counter in the same cycle.
REQ-019 Gaps in valid_i SHALL hold counter and accumulator unchanged.
REQ-020 Stage 3 on dump valid: integ_next = sat_ACC(integ + (dump >>> KI_SHIFT)), or integ if freeze_i = 1; integ <= integ_next.
REQ-021 Stage 3 SHALL register delta_phase_o = sat_DPW((dump >>> KP_SHIFT) + integ_next), pulse valid_o, set sat_o = 1 if clipped else 0.
REQ-022 sat_N SHALL clamp to [-2^(N-1), 2^(N-1)-1]; all shifts SHALL be arithmetic (floor).
REQ-023 Latency: valid_i of the dump-completing sample at cycle t SHALL give valid_o at cycle t+3.
REQ-024 delta_phase_o and sat_o SHALL hold between updates; valid_o SHALL be 0 except update cycles.
REQ-025 clear_i = 1 SHALL zero e, acc, counter, integ, all pipeline valids, delta_phase_o, sat_o, valid_o next cycle; clear_i overrides valid_i and freeze_i.
REQ-026 mode_i SHALL be sampled with each valid_i; changes mid-dump affect only later samples.

Reset
REQ-027 rst_n = 0 SHALL immediately, independent of clk, set delta_phase_o = 0, valid_o = 0, sat_o = 0, integrator, accumulator, counter and pipeline valids to 0.
REQ-028 After rst_n rises, the first dump SHALL complete on the DUMP_LEN-th valid sample.

Verification (defaults)
REQ-029 BPSK, 4 x (I=1000, Q=256) -> dump 1024, prop 64, integ 4, delta_phase_o = 68, valid_o 3 cycles after 4th sample, sat_o = 0.
REQ-030 QPSK, 4 x (I=-100, Q=200) -> e = -100, dump -400, prop -25, integ -2, delta_phase_o = -27.
REQ-031 BPSK, 4 x (I=32767, Q=32767) -> delta_phase_o = 511, sat_o = 1; same with Q=-32768 -> -512, sat_o = 1.
REQ-032 REQ-029 run, then freeze_i = 1 and repeat -> integ stays 4, delta_phase_o = 68; freeze_i = 0 and repeat -> 72.
REQ-033 Two samples, rst_n low mid-dump, release, four samples of REQ-029 -> delta_phase_o = 68 (no residue); same via clear_i; valid_i gaps inside a dump -> same result.
